axi_wr_traffic_gen: RTL
=======================

// Module: axi_wr_traffic_gen
// PURPOSE
//  Parametrised AXI write-channel traffic master replacing forced-stimulus fake_cpu writes in top-level benches.
//  Issues a programmed sequence of INCR write bursts (AW/W/B) with configurable address, stride, length and outstanding depth.
//  Counts B responses and errors, then pulses done. Sits in place of the fake_cpu write port, ahead of the axi_sram_bridge slave.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    64   data width, multiple of 32
//  ID_W      4    AXI ID width
//  AXI_ID    0    constant awid value
//  CNT_W     16   width of cfg_num_txn and internal txn counters
//  MAX_OUTST 4    max AW accepted without matching B (1..15)
// PORTS
//  clk            in   1          clock, all logic on posedge
//  reset          in   1          synchronous, active-high
//  start          in   1          1-cycle pulse; latches cfg_*; ignored while busy
//  cfg_base_addr  in   ADDR_W     address of txn 0
//  cfg_stride     in   ADDR_W     address increment per txn
//  cfg_num_txn    in   CNT_W      number of bursts
//  cfg_len        in   8          awlen (beats-1)
//  cfg_size       in   3          awsize
//  cfg_seed       in   DATA_W     first data word
//  busy           out  1          high from start accept until done
//  done           out  1          1-cycle pulse when last B accepted
//  err_cnt        out  CNT_W      bresp!=OKAY count, saturating, cleared on start
//  awid/awaddr/awlen/awsize/awburst  out  ID_W/ADDR_W/8/3/2   AW payload
//  awvalid out 1 / awready in 1
//  wdata/wstrb/wlast  out  DATA_W/DATA_W/8/1   W payload
//  wvalid out 1 / wready in 1
//  bid in ID_W, bresp in 2, bvalid in 1, bready out 1
// BEHAVIOUR
//  Reset: awvalid=wvalid=bready=busy=done=0, err_cnt=0, all payload outputs 0, FSM=IDLE.
//  Reset mid-operation abandons traffic next edge; no done pulse.
//  FSM IDLE->RUN on start&&cfg_num_txn!=0; start&&cfg_num_txn==0: done pulses next cycle, no traffic.
//  RUN->IDLE when b_cnt==num_txn (edge of last B handshake); done=1 for exactly that following cycle, busy=0.
//  AW txn i: awaddr=base+i*stride mod 2^ADDR_W (wraps silently); awlen=cfg_len, awsize=cfg_size, awburst=2'b01, awid=AXI_ID.
//  awvalid asserted when aw_cnt<num_txn && (aw_cnt-b_cnt)<MAX_OUTST; first awvalid 1 cycle after start.
//  W: burst j sent only after AW j accepted (aw_cnt>j); cfg_len+1 beats, wlast on final beat; back-to-back bursts allowed.
//  wdata = cfg_seed + k (k = global W beat index from 0, mod 2^DATA_W); wstrb all ones.
//  AXI rules: valid never deasserts before ready; payload stable while valid&&!ready; AW and W independent once eligible.
//  bready=1 throughout RUN, 0 in IDLE; B in IDLE not accepted. bid ignored.
//  Same-cycle AW and B handshakes: outstanding unchanged. bresp!=0: err_cnt+1, saturates at all ones.
//  Config latched at start; cfg_* changes while busy have no effect.
// CONFIGURATION
//  AXI_WR_GEN_LFSR_DATA_EN defined: wdata = {DATA_W/32 copies of lfsr32}; lfsr32 loads cfg_seed[31:0] at start
//   (0 maps to 32'h1), Galois taps x^32+x^22+x^2+x+1, advances once per W handshake.
//  Not defined: incrementing pattern above; no LFSR logic.
// TESTING
//  Single writes: base=0x4, stride=0xFC, num=2, len=0, size=2, seed=0xABCDAAAA12345678, ready=1
//   -> awaddr 0x4 then 0x100; wdata 0xABCDAAAA12345678 then ...79; wlast each beat; done after 2nd B.
//  Burst: num=3, len=3, wready 1-of-2 cycles -> 12 beats, wlast on beats 3,7,11, data seed..seed+11 held while stalled.
//  Outstanding: MAX_OUTST=4, num=8, bvalid held low -> exactly 4 AW handshakes, then awvalid=0 until a B arrives.
//  Errors/edges: bresp=2'b10 on 2 of 5 txns -> err_cnt=2; num=0 -> done next cycle, no valids; base=0xFFFFFFF0, stride=0x10 -> 2nd awaddr 0x0.
//  Reset at beat 5 of 12 -> next cycle all valids 0, busy 0, no done; fresh start completes normally.
//  LFSR build: seed=1, len=1 -> wdata lanes = 0x00000001, then 0x80200003.

Source files
------------

// File: rtl/axi_wr_traffic_gen.sv
// AXI write-channel traffic master: issues a programmed run of INCR bursts (AW/W/B),
// counts B errors and pulses done. Define AXI_WR_GEN_LFSR_DATA_EN for LFSR write data.

module axi_wr_traffic_gen #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [ADDR_W-1:0]   cfg_stride,
  input  logic [CNT_W-1:0]    cfg_num_txn,
  input  logic [7:0]          cfg_len,
  input  logic [2:0]          cfg_size,
  input  logic [DATA_W-1:0]   cfg_seed,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int                STRB_W      = DATA_W / 8;
  localparam logic [CNT_W-1:0]  MAX_OUTST_C = CNT_W'(MAX_OUTST);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic              done_q;

  // Configuration captured at start; cfg_* are ignored for the rest of the run.
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  num_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  aw_cnt;
  logic [CNT_W-1:0]  wb_cnt;
  logic [CNT_W-1:0]  b_cnt;
  logic [7:0]        beat_cnt;
  logic [CNT_W-1:0]  err_q;

  logic              run;
  logic              start_ok;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              last_b;
  logic [CNT_W-1:0]  outst;

  assign run      = (state == ST_RUN);
  assign start_ok = start && (state == ST_IDLE);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready;
  assign outst    = aw_cnt - b_cnt;
  assign last_b   = b_hs && ((b_cnt + CNT_W'(1)) == num_q);

  // Valids are pure functions of registered counters: eligibility can only be lost
  // through the handshake that consumes it, so a raised valid is held until ready.
  assign awvalid = run && (aw_cnt < num_q) && (outst < MAX_OUTST_C);
  assign wvalid  = run && (wb_cnt < aw_cnt);
  assign bready  = run;
  assign busy    = run;
  assign done    = done_q;
  assign err_cnt = err_q;

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = run ? 2'b01 : 2'b00;
  assign wstrb   = {STRB_W{run}};
  assign wlast   = run && (beat_cnt == len_q);

  always_comb begin
    // NOTE: default assignment first so every path drives state_next; no latch.
    state_next = state;
    case (state)
      ST_IDLE: if (start && (cfg_num_txn != '0)) state_next = ST_RUN;
      ST_RUN:  if (last_b)                       state_next = ST_IDLE;
      default:                                   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= ST_IDLE;
      done_q   <= 1'b0;
      stride_q <= '0;
      num_q    <= '0;
      len_q    <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      aw_cnt   <= '0;
      wb_cnt   <= '0;
      b_cnt    <= '0;
      beat_cnt <= '0;
      err_q    <= '0;
    end else begin
      state  <= state_next;
      done_q <= (start_ok && (cfg_num_txn == '0)) || last_b;

      if (start_ok) begin
        stride_q <= cfg_stride;
        num_q    <= cfg_num_txn;
        len_q    <= cfg_len;
        size_q   <= cfg_size;
        addr_q   <= cfg_base_addr;
        aw_cnt   <= '0;
        wb_cnt   <= '0;
        b_cnt    <= '0;
        beat_cnt <= '0;
        err_q    <= '0;
      end else if (run) begin
        if (aw_hs) begin
          aw_cnt <= aw_cnt + CNT_W'(1);
          addr_q <= addr_q + stride_q;
        end
        if (w_hs) begin
          if (beat_cnt == len_q) begin
            beat_cnt <= '0;
            wb_cnt   <= wb_cnt + CNT_W'(1);
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        if (b_hs) begin
          b_cnt <= b_cnt + CNT_W'(1);
          if ((bresp != 2'b00) && (err_q != '1)) err_q <= err_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef AXI_WR_GEN_LFSR_DATA_EN
  // Galois form of x^32+x^22+x^2+x+1, shifting right; an all-zero seed would lock up.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_next;
  logic        unused_inputs;

  assign lfsr_next     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
  assign wdata         = {(DATA_W/32){lfsr_q}};
  assign unused_inputs = ^{bid, cfg_seed};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= '0;
    end else if (start_ok) begin
      lfsr_q <= (cfg_seed[31:0] == 32'h0) ? 32'h1 : cfg_seed[31:0];
    end else if (run && w_hs) begin
      lfsr_q <= lfsr_next;
    end
  end
`else
  logic [DATA_W-1:0] data_q;
  logic              unused_inputs;

  assign wdata         = data_q;
  assign unused_inputs = ^bid;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (start_ok) begin
      data_q <= cfg_seed;
    end else if (run && w_hs) begin
      data_q <= data_q + DATA_W'(1);
    end
  end
`endif

endmodule
